// File: rtl/mb_data_xfer.sv
// Drive-side Massbus sector transfer sequencer: devREQO/devACKI handshake, one word per 3 cycles.
// Optional write-check compare enabled by MB_WRCHK_EN; without it func=10 completes as illegal.
module mb_data_xfer #(
  parameter int BUFDEPTH = 128,
  parameter int AW       = $clog2(BUFDEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          devRESET,
  input  logic          start,
  input  logic [1:0]    func,
  input  logic [15:0]   rhWC,
  output logic          devREQO,
  input  logic          devACKI,
  input  logic [35:0]   devDATAI,
  output logic [35:0]   devDATAO,
  output logic          incBA4,
  output logic          incWC2,
  output logic          setNPRO,
  output logic          setWCE,
  output logic [AW-1:0] bufADDR,
  output logic          bufWR,
  output logic [35:0]   bufWDATA,
  input  logic [35:0]   bufRDATA,
  output logic          busy,
  output logic          done,
  output logic          sectEnd,
  output logic          funcErr
);

  localparam logic [1:0] FN_WRITE = 2'b00;
  localparam logic [1:0] FN_READ  = 2'b01;

  typedef enum logic [2:0] {IDLE, FETCH, REQ, XFER, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] index;
  logic [1:0]    func_q;
  logic [35:0]   data_q;
  logic          last_q;
  logic          sect_q;
  logic          ferr_q;
  logic          req_seen;
  logic          func_illegal;
  logic          at_end;
  logic          wce;

  assign at_end = (index == AW'(BUFDEPTH - 1));

`ifdef MB_WRCHK_EN
  logic wce_q;

  assign func_illegal = (func == 2'b11);
  assign wce          = wce_q;

  // bufADDR is held at index through REQ, so bufRDATA still holds the fetched word at the ack edge.
  always_ff @(posedge clk) begin
    if (rst || devRESET) begin
      wce_q <= 1'b0;
    end else if (state == REQ && devACKI) begin
      wce_q <= (func_q == 2'b10) && (devDATAI != bufRDATA);
    end
  end
`else
  assign func_illegal = func[1];
  assign wce          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || devRESET) begin
      state    <= IDLE;
      index    <= '0;
      func_q   <= 2'b00;
      data_q   <= '0;
      last_q   <= 1'b0;
      sect_q   <= 1'b0;
      ferr_q   <= 1'b0;
      req_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            func_q   <= func;
            index    <= '0;
            req_seen <= 1'b0;
            sect_q   <= 1'b0;
            ferr_q   <= (rhWC != 16'h0000) && func_illegal;
          end
        end
        REQ: begin
          req_seen <= 1'b1;
          if (devACKI) begin
            data_q <= devDATAI;
            last_q <= (rhWC == 16'hFFFE);
          end
        end
        XFER: begin
          index  <= index + AW'(1);
          sect_q <= at_end && !last_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    devREQO   = 1'b0;
    devDATAO  = '0;
    incBA4    = 1'b0;
    incWC2    = 1'b0;
    setNPRO   = 1'b0;
    setWCE    = 1'b0;
    bufADDR   = '0;
    bufWR     = 1'b0;
    bufWDATA  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    sectEnd   = 1'b0;
    funcErr   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (rhWC == 16'h0000 || func_illegal) state_nxt = DONE;
          else                                  state_nxt = FETCH;
        end
      end
      FETCH: begin
        busy      = 1'b1;
        bufADDR   = index;
        state_nxt = REQ;
      end
      REQ: begin
        busy    = 1'b1;
        bufADDR = index;
        devREQO = 1'b1;
        setNPRO = !req_seen;
        if (func_q == FN_READ) devDATAO = bufRDATA;
        if (devACKI) state_nxt = XFER;
      end
      XFER: begin
        busy    = 1'b1;
        bufADDR = index;
        incBA4  = 1'b1;
        incWC2  = 1'b1;
        setWCE  = wce;
        if (func_q == FN_WRITE) begin
          bufWR    = 1'b1;
          bufWDATA = data_q;
        end
        if (last_q || wce || at_end) state_nxt = DONE;
        else                         state_nxt = FETCH;
      end
      DONE: begin
        done      = 1'b1;
        sectEnd   = sect_q;
        funcErr   = ferr_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mb_data_xfer.sv
// Directed bench for mb_data_xfer with BUFDEPTH=4, a registered-read buffer model and an RH11 that
// acks one cycle after each request and steps rhWC by 2 on every incWC2.
module tb_mb_data_xfer;
  localparam int BD = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          devRESET = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    func = 2'b00;
  logic [15:0]   rhWC = 16'h0000;
  logic          devREQO;
  logic          devACKI = 1'b0;
  logic [35:0]   devDATAI = '0;
  logic [35:0]   devDATAO;
  logic          incBA4, incWC2, setNPRO, setWCE;
  logic [AW-1:0] bufADDR;
  logic          bufWR;
  logic [35:0]   bufWDATA;
  logic [35:0]   bufRDATA = '0;
  logic          busy, done, sectEnd, funcErr;

  mb_data_xfer #(.BUFDEPTH(BD)) dut (
    .clk(clk), .rst(rst), .devRESET(devRESET), .start(start), .func(func), .rhWC(rhWC),
    .devREQO(devREQO), .devACKI(devACKI), .devDATAI(devDATAI), .devDATAO(devDATAO),
    .incBA4(incBA4), .incWC2(incWC2), .setNPRO(setNPRO), .setWCE(setWCE),
    .bufADDR(bufADDR), .bufWR(bufWR), .bufWDATA(bufWDATA), .bufRDATA(bufRDATA),
    .busy(busy), .done(done), .sectEnd(sectEnd), .funcErr(funcErr)
  );

  always #5 clk = ~clk;

  logic [35:0] mem [BD];
  logic [35:0] pl_val [BD];
  logic        pl_go = 1'b0;

  always @(posedge clk) begin
    bufRDATA <= mem[bufADDR];
    if (pl_go) for (int i = 0; i < BD; i++) mem[i] <= pl_val[i];
    else if (bufWR) mem[bufADDR] <= bufWDATA;
  end

  int total = 0;
  int passed = 0;

  logic [35:0] wdat [BD];
  int n_req, n_inc, n_ba, n_npro, n_wce, wce_cyc, wce_inc, done_cyc, first_req;
  logic done_sect, done_ferr, busy_c1, busy_at_done, timed_out;
  logic [35:0] rd_words [$];
  logic [AW-1:0] wr_addr [$];
  logic [35:0] wr_data [$];
  logic [83:0] outs;

  task automatic preload(input logic [35:0] a, b, c, d);
    pl_val[0] = a; pl_val[1] = b; pl_val[2] = c; pl_val[3] = d;
    pl_go = 1'b1;
    @(posedge clk); #1;
    pl_go = 1'b0;
  endtask

  // Starts one transfer and records what the DUT does until three cycles after done.
  task automatic run_xfer(input logic [1:0] f, input logic [15:0] wc, input int restart_cyc);
    int age, acks, post;
    logic seen, prev_req;
    n_req = 0; n_inc = 0; n_ba = 0; n_npro = 0; n_wce = 0; wce_cyc = -1; wce_inc = -1;
    done_cyc = -1; first_req = -1; done_sect = 0; done_ferr = 0; busy_c1 = 0;
    busy_at_done = 1; timed_out = 0;
    rd_words.delete(); wr_addr.delete(); wr_data.delete();
    age = 0; acks = 0; post = 0; seen = 0; prev_req = 0;
    func = f; rhWC = wc; start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 120 && post < 3; cyc++) begin
      start = (cyc == restart_cyc);
      if (devREQO && !prev_req) begin
        n_req++;
        if (first_req < 0) first_req = cyc;
      end
      prev_req = devREQO;
      if (setNPRO) n_npro++;
      if (incBA4) n_ba++;
      if (incWC2) begin n_inc++; rhWC = rhWC + 16'd2; end
      if (setWCE) begin n_wce++; wce_cyc = cyc; wce_inc = n_inc; end
      if (bufWR) begin wr_addr.push_back(bufADDR); wr_data.push_back(bufWDATA); end
      if (cyc == 1) busy_c1 = busy;
      if (done) begin
        seen = 1; done_cyc = cyc; done_sect = sectEnd; done_ferr = funcErr; busy_at_done = busy;
      end
      if (seen) post++;
      devACKI = 1'b0;
      if (devREQO) begin
        if (age == 1) begin
          devACKI = 1'b1;
          devDATAI = wdat[acks % BD];
          rd_words.push_back(devDATAO);
          acks++;
        end
        age++;
      end else begin
        age = 0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; devACKI = 1'b0;
    if (!seen) timed_out = 1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    outs = {devREQO, devDATAO, incBA4, incWC2, setNPRO, setWCE, bufADDR, bufWR, bufWDATA,
            busy, done, sectEnd, funcErr};
    total++; if (outs !== '0) $display("FAIL reset_outputs: got %0h want 0", outs); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read;
    preload(36'd1, 36'd2, 36'd3, 36'd4);
    run_xfer(2'b01, 16'hFFFC, 0);
    total++; if (timed_out !== 1'b0) $display("FAIL read_timeout: got %0b want 0", timed_out); else passed++;
    total++; if (first_req !== 2) $display("FAIL read_start_to_req: got %0d want 2", first_req); else passed++;
    total++; if (n_npro !== 1) $display("FAIL read_setNPRO: got %0d want 1", n_npro); else passed++;
    total++; if (rd_words.size() !== 2) $display("FAIL read_words: got %0d want 2", rd_words.size()); else passed++;
    total++; if (rd_words[0] !== 36'd1) $display("FAIL read_word0: got %0h want 1", rd_words[0]); else passed++;
    total++; if (rd_words[1] !== 36'd2) $display("FAIL read_word1: got %0h want 2", rd_words[1]); else passed++;
    total++; if (n_inc !== 2) $display("FAIL read_incWC2: got %0d want 2", n_inc); else passed++;
    total++; if (done_cyc !== 9) $display("FAIL read_done_cycle: got %0d want 9", done_cyc); else passed++;
    total++; if (done_sect !== 1'b0) $display("FAIL read_sectEnd: got %0b want 0", done_sect); else passed++;
    total++; if (busy_c1 !== 1'b1) $display("FAIL read_busy_early: got %0b want 1", busy_c1); else passed++;
    total++; if (busy_at_done !== 1'b0) $display("FAIL read_busy_at_done: got %0b want 0", busy_at_done); else passed++;
    total++; if (wr_addr.size() !== 0) $display("FAIL read_no_bufwr: got %0d want 0", wr_addr.size()); else passed++;
  endtask

  task automatic test_write;
    logic [35:0] base;
    base = 36'o123456701234;
    for (int k = 0; k < BD; k++) wdat[k] = base + 36'(k);
    preload(36'd0, 36'd0, 36'd0, 36'd0);
    run_xfer(2'b00, 16'hFFF0, 0);
    total++; if (wr_addr.size() !== 4) $display("FAIL write_count: got %0d want 4", wr_addr.size()); else passed++;
    for (int k = 0; k < BD; k++) begin
      total++; if (wr_addr[k] !== AW'(k)) $display("FAIL write_addr%0d: got %0d want %0d", k, wr_addr[k], k); else passed++;
      total++; if (wr_data[k] !== base + 36'(k)) $display("FAIL write_data%0d: got %0h want %0h", k, wr_data[k], base + 36'(k)); else passed++;
    end
    total++; if (done_sect !== 1'b1) $display("FAIL write_sectEnd: got %0b want 1", done_sect); else passed++;
    total++; if (n_ba !== 4) $display("FAIL write_incBA4: got %0d want 4", n_ba); else passed++;
    total++; if (done_cyc !== 17) $display("FAIL write_done_cycle: got %0d want 17", done_cyc); else passed++;
  endtask

  task automatic test_wrchk;
    preload(36'h10, 36'h20, 36'h30, 36'h40);
    wdat[0] = 36'h10; wdat[1] = 36'h99; wdat[2] = 36'h30; wdat[3] = 36'h40;
    run_xfer(2'b10, 16'hFFF0, 0);
`ifdef MB_WRCHK_EN
    total++; if (n_wce !== 1) $display("FAIL wrchk_setWCE: got %0d want 1", n_wce); else passed++;
    total++; if (wce_inc !== 2) $display("FAIL wrchk_wce_with_inc: got %0d want 2", wce_inc); else passed++;
    total++; if (done_cyc !== wce_cyc + 1) $display("FAIL wrchk_done_after: got %0d want %0d", done_cyc, wce_cyc + 1); else passed++;
    total++; if (n_req !== 2) $display("FAIL wrchk_reqs: got %0d want 2", n_req); else passed++;
    total++; if (done_ferr !== 1'b0) $display("FAIL wrchk_funcErr: got %0b want 0", done_ferr); else passed++;
`else
    total++; if (n_req !== 0) $display("FAIL wrchk_off_reqs: got %0d want 0", n_req); else passed++;
    total++; if (done_ferr !== 1'b1) $display("FAIL wrchk_off_funcErr: got %0b want 1", done_ferr); else passed++;
    total++; if (done_cyc !== 1) $display("FAIL wrchk_off_done_cycle: got %0d want 1", done_cyc); else passed++;
    total++; if (n_wce !== 0) $display("FAIL wrchk_off_setWCE: got %0d want 0", n_wce); else passed++;
`endif
  endtask

  task automatic test_zero_illegal;
    run_xfer(2'b01, 16'h0000, 0);
    total++; if ((done_cyc >= 1 && done_cyc <= 2) !== 1'b1) $display("FAIL wc0_done_cycle: got %0d want 1..2", done_cyc); else passed++;
    total++; if (n_req !== 0) $display("FAIL wc0_reqs: got %0d want 0", n_req); else passed++;
    total++; if (done_ferr !== 1'b0) $display("FAIL wc0_funcErr: got %0b want 0", done_ferr); else passed++;
    run_xfer(2'b11, 16'hFFFC, 0);
    total++; if ((done_cyc >= 1 && done_cyc <= 2) !== 1'b1) $display("FAIL ill_done_cycle: got %0d want 1..2", done_cyc); else passed++;
    total++; if (n_req !== 0) $display("FAIL ill_reqs: got %0d want 0", n_req); else passed++;
    total++; if (done_ferr !== 1'b1) $display("FAIL ill_funcErr: got %0b want 1", done_ferr); else passed++;
  endtask

  task automatic test_dev_reset;
    int n;
    logic d;
    preload(36'd1, 36'd2, 36'd3, 36'd4);
    func = 2'b00; rhWC = 16'hFFF0; devACKI = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (devREQO) n++;
      if (n >= 5) break;
      @(posedge clk); #1;
    end
    total++; if (n !== 5) $display("FAIL devreset_req_held: got %0d want 5", n); else passed++;
    devRESET = 1'b1;
    @(posedge clk); #1;
    devRESET = 1'b0;
    outs = {devREQO, devDATAO, incBA4, incWC2, setNPRO, setWCE, bufADDR, bufWR, bufWDATA,
            busy, done, sectEnd, funcErr};
    total++; if (outs !== '0) $display("FAIL devreset_outputs: got %0h want 0", outs); else passed++;
    d = 1'b0;
    repeat (3) begin @(posedge clk); #1; d = d | done; end
    total++; if (d !== 1'b0) $display("FAIL devreset_no_done: got %0b want 0", d); else passed++;
    run_xfer(2'b01, 16'hFFFC, 0);
    total++; if (rd_words[0] !== 36'd1) $display("FAIL devreset_restart_word0: got %0h want 1", rd_words[0]); else passed++;
    total++; if (n_inc !== 2) $display("FAIL devreset_restart_inc: got %0d want 2", n_inc); else passed++;
  endtask

  task automatic test_ignored;
    preload(36'd1, 36'd2, 36'd3, 36'd4);
    devACKI = 1'b1;
    @(posedge clk); #1;
    devACKI = 1'b0;
    total++; if ({devREQO, busy, incWC2} !== 3'b000) $display("FAIL idle_ack: got %0b want 000", {devREQO, busy, incWC2}); else passed++;
    run_xfer(2'b01, 16'hFFFC, 4);
    total++; if (n_inc !== 2) $display("FAIL busy_start_inc: got %0d want 2", n_inc); else passed++;
    total++; if (rd_words.size() !== 2) $display("FAIL busy_start_words: got %0d want 2", rd_words.size()); else passed++;
    total++; if (done_cyc !== 9) $display("FAIL busy_start_done_cycle: got %0d want 9", done_cyc); else passed++;
    total++; if (n_req !== 2) $display("FAIL busy_start_reqs: got %0d want 2", n_req); else passed++;
  endtask

  initial begin
    for (int k = 0; k < BD; k++) wdat[k] = '0;
    test_reset();
    test_read();
    test_zero_illegal();
    test_dev_reset();
    test_ignored();
    test_wrchk();
    test_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
